// File: rtl/bq_energy_trigger_if.sv
// Sample-stream and result bundle between the biquad pair, the energy trigger and its consumer.
interface bq_energy_trigger_if #(
    parameter int NSAMP = 8,
    parameter int NBITS = 12,
    parameter int ACC_W = 23
);
    logic [NSAMP*NBITS-1:0] dat_i;
    logic                   dat_valid_i;
    logic [ACC_W-1:0]       energy_o;
    logic                   energy_valid_o;
    logic                   trig_o;
    logic [15:0]            sat_count_o;

    modport master (
        output dat_i, dat_valid_i,
        input  energy_o, energy_valid_o, trig_o, sat_count_o
    );

    modport slave (
        input  dat_i, dat_valid_i,
        output energy_o, energy_valid_o, trig_o, sat_count_o
    );
endinterface

// File: rtl/bq_energy_trigger.sv
// Windowed sum-of-|x| energy detector with strict-threshold trigger, holdoff and full-scale counter.
//
// state | meaning
// IDLE  | windows stopped; accumulator and beat count held at zero
// ACCUM | summing valid beats; window closes when wcnt reaches wlen
module bq_energy_trigger #(
    parameter int NSAMP = 8,
    parameter int NBITS = 12,
    parameter int WIN_W = 8,
    parameter int ACC_W = NBITS + 3 + WIN_W
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    bq_energy_trigger_if.slave    bus,
    input  logic                  enable_i,
    input  logic [WIN_W-1:0]      win_len_i,
    input  logic [ACC_W-1:0]      threshold_i,
    input  logic [15:0]           holdoff_i,
    input  logic                  sat_clr_i
);
    localparam int SUM_W = NBITS + 3;
    localparam int PC_W  = $clog2(NSAMP + 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    logic [NBITS-1:0] mag_c  [NSAMP];
    logic [NBITS-1:0] mag_s1 [NSAMP];
    logic [NSAMP-1:0] fs_c, fs_s1;
    logic             vld_s1;
    logic [SUM_W-1:0] sum_c, sum_s2;
    logic [PC_W-1:0]  pc_c, pc_s2;
    logic             vld_s2;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt, energy_nxt;
    logic [WIN_W-1:0] wcnt, wcnt_nxt, wlen, wlen_nxt;
    logic             ev_nxt;
    logic [15:0]      hcnt;
    logic             trig_fire;
    logic [16:0]      sat_sum;

    // The most-negative code negates to 2^(NBITS-1), which still fits as unsigned NBITS.
    always_comb begin
        for (int k = 0; k < NSAMP; k++) begin
            logic [NBITS-1:0] x;
            x        = bus.dat_i[NBITS*k +: NBITS];
            mag_c[k] = x[NBITS-1] ? (~x + 1'b1) : x;
            fs_c[k]  = (x == {1'b1, {(NBITS-1){1'b0}}}) || (x == {1'b0, {(NBITS-1){1'b1}}});
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < NSAMP; k++) mag_s1[k] <= '0;
            fs_s1  <= '0;
            vld_s1 <= 1'b0;
        end else begin
            for (int k = 0; k < NSAMP; k++) mag_s1[k] <= mag_c[k];
            fs_s1  <= fs_c;
            vld_s1 <= bus.dat_valid_i;
        end
    end

    always_comb begin
        sum_c = '0;
        pc_c  = '0;
        for (int k = 0; k < NSAMP; k++) begin
            sum_c = sum_c + SUM_W'(mag_s1[k]);
            pc_c  = pc_c + PC_W'(fs_s1[k]);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sum_s2 <= '0;
            pc_s2  <= '0;
            vld_s2 <= 1'b0;
        end else begin
            sum_s2 <= sum_c;
            pc_s2  <= pc_c;
            vld_s2 <= vld_s1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state              <= IDLE;
            acc                <= '0;
            wcnt               <= '0;
            wlen               <= '0;
            bus.energy_o       <= '0;
            bus.energy_valid_o <= 1'b0;
        end else begin
            state              <= state_nxt;
            acc                <= acc_nxt;
            wcnt               <= wcnt_nxt;
            wlen               <= wlen_nxt;
            bus.energy_o       <= energy_nxt;
            bus.energy_valid_o <= ev_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        wcnt_nxt   = wcnt;
        wlen_nxt   = wlen;
        energy_nxt = bus.energy_o;
        ev_nxt     = 1'b0;
        case (state)
            IDLE: begin
                acc_nxt  = '0;
                wcnt_nxt = '0;
                if (enable_i) begin
                    state_nxt = ACCUM;
                    wlen_nxt  = win_len_i;
                end
            end
            ACCUM: begin
                if (!enable_i) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                    wcnt_nxt  = '0;
                end else if (vld_s2) begin
                    // Closing beat folds into the result directly so windows abut with no gap.
                    if (wcnt == wlen) begin
                        energy_nxt = acc + ACC_W'(sum_s2);
                        ev_nxt     = 1'b1;
                        acc_nxt    = '0;
                        wcnt_nxt   = '0;
                        wlen_nxt   = win_len_i;
                    end else begin
                        acc_nxt  = acc + ACC_W'(sum_s2);
                        wcnt_nxt = wcnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A window closing while holdoff is still running is dropped, never queued.
    assign trig_fire = bus.energy_valid_o && (bus.energy_o > threshold_i) && (hcnt == '0);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bus.trig_o <= 1'b0;
            hcnt       <= '0;
        end else begin
            bus.trig_o <= trig_fire;
            if (trig_fire)        hcnt <= holdoff_i;
            else if (hcnt != '0)  hcnt <= hcnt - 16'd1;
        end
    end

    assign sat_sum = {1'b0, bus.sat_count_o} + 17'(pc_s2);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)         bus.sat_count_o <= '0;
        else if (sat_clr_i)   bus.sat_count_o <= '0;
        else if (vld_s2)      bus.sat_count_o <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
endmodule
